// File: rtl/fir_sample_serializer_if.sv
// rtl/fir_sample_serializer_if.sv - parallel sample handshake between FIR output stage and serializer
interface fir_sample_serializer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data_in;
    logic              in_valid;
    logic              in_ready;

    // FIR output stage drives samples
    modport master (
        output data_in,
        output in_valid,
        input  in_ready
    );

    // Serializer accepts samples
    modport slave (
        input  data_in,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/fir_sample_serializer.sv
// rtl/fir_sample_serializer.sv - FIFO-buffered MSB-first serial transmitter for FIR output samples
module fir_sample_serializer #(
    parameter int DATA_W     = 16,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    fir_sample_serializer_if.slave  in_if,
    output logic                    sclk,
    output logic                    sdata,
    output logic                    sync,
    output logic                    busy,
    output logic                    overflow,
    output logic [15:0]             word_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_MAX       = BIT_W'(DATA_W - 1);
    localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [BIT_W-1:0]    bit_idx_q,    bit_idx_d;
    logic [DATA_W-1:0]   sr_q,         sr_d;
    logic [15:0]         word_count_q, word_count_d;
    logic                overflow_q,   overflow_d;
    logic [PTR_W-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [PTR_W:0]      fifo_cnt_q,   fifo_cnt_d;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   fifo_head;

    assign fifo_full  = (fifo_cnt_q == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // in_ready depends only on the occupancy count, never on in_valid
    assign in_if.in_ready = ~fifo_full;
    assign push           = in_if.in_valid & ~fifo_full;

    // FIFO storage: written on accepted pushes; contents are don't-care when empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_if.data_in;
        end
    end

    // FIFO pointers/occupancy and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        overflow_d = overflow_q | (in_if.in_valid & fifo_full);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (PTR_W + 1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (PTR_W + 1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Transmit FSM next-state: loads a word from the FIFO head and walks cnt/bit_idx
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        sr_d         = sr_q;
        word_count_d = word_count_q;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    sr_d      = fifo_head;
                    bit_idx_d = BIT_MAX;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (bit_idx_q == '0) begin
                        word_count_d = word_count_q + 16'd1;
                        if (!fifo_empty) begin
                            // back-to-back word, no idle gap on the link
                            pop       = 1'b1;
                            sr_d      = fifo_head;
                            bit_idx_d = BIT_MAX;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q - BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; async reset abandons any partial word and empties the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            sr_q         <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            sr_q         <= sr_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

    // Serial outputs decoded purely from registered state, forced quiet in IDLE
    always_comb begin
        busy  = (state_q == ST_SHIFT);
        sdata = busy & sr_q[bit_idx_q];
        sclk  = busy & (cnt_q >= CNT_HALF);
        sync  = busy & (bit_idx_q == BIT_MAX);
    end

    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_fir_sample_serializer.sv
// tb/tb_fir_sample_serializer.sv - scoreboard bench for fir_sample_serializer
module tb_fir_sample_serializer;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        sclk, sdata, sync, busy, overflow;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    fir_sample_serializer_if #(.DATA_W(16)) in_if ();

    fir_sample_serializer #(
        .DATA_W     (16),
        .BCLK_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (in_if),
        .sclk       (sclk),
        .sdata      (sdata),
        .sync       (sync),
        .busy       (busy),
        .overflow   (overflow),
        .word_count (word_count)
    );

    int          n_pass   = 0;
    int          n_total  = 0;
    int          n_fail   = 0;
    int          rx_words = 0;
    int          exp_wc   = 0;
    logic [15:0] sc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial receiver: shifts on sclk rising, frames on sync, checks against the scoreboard
    logic [15:0] rx_sr     = '0;
    int          rx_bits   = 0;
    logic        sclk_prev = 1'b0;
    logic [15:0] exp_word;

    always @(negedge clk) begin
        if (!reset) begin
            rx_bits   = 0;
            sclk_prev = 1'b0;
        end else begin
            if (sclk && !sclk_prev) begin
                if (sync) begin
                    rx_sr   = {15'd0, sdata};
                    rx_bits = 1;
                end else begin
                    rx_sr   = {rx_sr[14:0], sdata};
                    rx_bits = rx_bits + 1;
                end
                if (rx_bits == 16) begin
                    rx_bits  = 0;
                    rx_words = rx_words + 1;
                    chk("rx_word_was_expected", (sc.size() > 0), 1);
                    if (sc.size() > 0) begin
                        exp_word = sc.pop_front();
                        chk("rx_word_value", rx_sr, exp_word);
                    end
                end
            end
            sclk_prev = sclk;
        end
    end

    // Pushes one or two words on consecutive cycles and checks every cycle of the serial burst
    task automatic send_and_check(input string tag, input logic [15:0] w0, input logic [15:0] w1, input int n);
        int          e_busy = 0, e_sync = 0, e_sclk = 0, e_sdata = 0, busy_cycles = 0;
        int          pos;
        logic [15:0] w;
        logic        eb, es, ek, ed;
        @(negedge clk);
        in_if.data_in  = w0;
        in_if.in_valid = 1'b1;
        sc.push_back(w0);
        @(negedge clk);
        if (n == 2) begin
            in_if.data_in = w1;
            sc.push_back(w1);
        end else begin
            in_if.in_valid = 1'b0;
        end
        for (int k = 1; k <= 64 * n + 6; k++) begin
            @(negedge clk);
            if (k == 1) in_if.in_valid = 1'b0;
            if (k <= 64 * n) begin
                pos = (k - 1) % 64;
                w   = (((k - 1) / 64) == 0) ? w0 : w1;
                eb  = 1'b1;
                es  = (pos < 4);
                ek  = ((pos % 4) >= 2);
                ed  = w[15 - pos / 4];
            end else begin
                eb = 1'b0; es = 1'b0; ek = 1'b0; ed = 1'b0;
            end
            if (busy  !== eb) e_busy++;
            if (sync  !== es) e_sync++;
            if (sclk  !== ek) e_sclk++;
            if (sdata !== ed) e_sdata++;
            if (busy === 1'b1) busy_cycles++;
        end
        chk({tag, "_busy_cycles"}, busy_cycles, 64 * n);
        chk({tag, "_busy_pattern_errs"}, e_busy, 0);
        chk({tag, "_sync_pattern_errs"}, e_sync, 0);
        chk({tag, "_sclk_pattern_errs"}, e_sclk, 0);
        chk({tag, "_sdata_pattern_errs"}, e_sdata, 0);
    endtask

    int idle_busy;

    initial begin
        in_if.in_valid = 1'b0;
        in_if.data_in  = '0;
        #1 reset = 1'b0;
        #2;
        chk("reset_serial_outputs", {sdata, sclk, sync, busy}, 4'b0000);
        chk("reset_overflow", overflow, 0);
        chk("reset_word_count", word_count, 0);
        chk("reset_in_ready", in_if.in_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // single word with mixed bit pattern
        send_and_check("t1", 16'hA5C3, 16'h0000, 1);
        exp_wc += 1;
        chk("t1_word_count", word_count, exp_wc);
        chk("t1_idle_sdata", sdata, 0);

        // two words back to back, sync on each MSB
        send_and_check("t2", 16'h8001, 16'h7FFE, 2);
        exp_wc += 2;
        chk("t2_word_count", word_count, exp_wc);

        // all ones then all zeros
        send_and_check("t3", 16'hFFFF, 16'h0000, 2);
        exp_wc += 2;
        chk("t3_word_count", word_count, exp_wc);

        // overflow: six consecutive valids into a 4-deep FIFO
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            in_if.data_in  = 16'(i + 1);
            in_if.in_valid = 1'b1;
            if (i < 5) sc.push_back(16'(i + 1));
            if (i == 4) chk("t4_in_ready_5th", in_if.in_ready, 1);
            if (i == 5) chk("t4_in_ready_6th", in_if.in_ready, 0);
        end
        @(negedge clk);
        in_if.in_valid = 1'b0;
        chk("t4_overflow_set", overflow, 1);
        repeat (400) @(negedge clk);
        exp_wc += 5;
        chk("t4_overflow_sticky", overflow, 1);
        chk("t4_scoreboard_drained", sc.size(), 0);
        chk("t4_rx_words", rx_words, 10);
        chk("t4_word_count", word_count, exp_wc);

        // asynchronous reset mid-word with two samples queued
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            in_if.data_in  = (i == 0) ? 16'h00FF : 16'(16'h1111 * (i + 1));
            in_if.in_valid = 1'b1;
            sc.push_back(in_if.data_in);
        end
        @(negedge clk);
        in_if.in_valid = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        chk("t5_pre_busy", busy, 1);
        chk("t5_pre_sdata_bit7", sdata, 1);
        chk("t5_pre_sclk", sclk, 1);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_serial_outputs", {sdata, sclk, sync, busy}, 4'b0000);
        chk("t5_rst_overflow", overflow, 0);
        chk("t5_rst_word_count", word_count, 0);
        chk("t5_rst_in_ready", in_if.in_ready, 1);
        sc.delete();
        exp_wc = 0;
        @(negedge clk);
        reset = 1'b1;
        idle_busy = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_busy++;
        end
        chk("t5_no_tx_after_reset", idle_busy, 0);
        chk("t5_rx_words_unchanged", rx_words, 10);

        // word_count wrap from 0xFFFF
        @(negedge clk);
        force dut.word_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.word_count_q;
        @(negedge clk);
        chk("t6_preload", word_count, 16'hFFFF);
        send_and_check("t6", 16'h5A96, 16'h0000, 1);
        chk("t6_word_count_wrap", word_count, 16'h0000);

        chk("final_rx_words", rx_words, 11);
        chk("final_scoreboard_empty", sc.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
